// File: rtl/absmem_wlog_if.sv
// Memory-port bundle for absmem_wlog: RTL-side (vlg_*) and ILA-side (ila_*) ports,
// plus the issue/compare controls and the equal/overflow results.
interface absmem_wlog_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          issue;
    logic          compare;
    logic [AW-1:0] vlg_raddr, vlg_waddr, ila_raddr, ila_waddr;
    logic          vlg_ren, vlg_wen, ila_ren, ila_wen;
    logic [DW-1:0] vlg_wdata, vlg_r_rand_input, ila_wdata, ila_r_rand_input;
    logic [DW-1:0] vlg_rdata, ila_rdata;
    logic          equal, vlg_ovf, ila_ovf;

    modport master (
        output issue, compare,
        output vlg_raddr, vlg_ren, vlg_waddr, vlg_wdata, vlg_wen, vlg_r_rand_input,
        output ila_raddr, ila_ren, ila_waddr, ila_wdata, ila_wen, ila_r_rand_input,
        input  vlg_rdata, ila_rdata, equal, vlg_ovf, ila_ovf
    );

    modport slave (
        input  issue, compare,
        input  vlg_raddr, vlg_ren, vlg_waddr, vlg_wdata, vlg_wen, vlg_r_rand_input,
        input  ila_raddr, ila_ren, ila_waddr, ila_wdata, ila_wen, ila_r_rand_input,
        output vlg_rdata, ila_rdata, equal, vlg_ovf, ila_ovf
    );
endinterface

// File: rtl/absmem_wlog.sv
// Abstract 1R/1W dual-view memory: shared symbolic image plus a coalescing write log per side.
// Optional macro ABSMEM_WR_BYPASS_EN makes same-side same-address read/write write-first.
module absmem_wlog_side #(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int NW = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ren_real,
    input  logic [AW-1:0]          raddr,
    input  logic [DW-1:0]          mem_rd,
    input  logic [DW-1:0]          rrand,
    output logic [DW-1:0]          rdata,
    input  logic                   wen_real,
    input  logic [AW-1:0]          waddr,
    input  logic [DW-1:0]          wdata,
    output logic [NW-1:0]          vld,
    output logic [NW-1:0][AW-1:0]  addr,
    output logic [NW-1:0][DW-1:0]  data,
    output logic                   ovf
);
    localparam int CW = $clog2(NW + 1);

    logic [CW-1:0] cnt;
    logic [NW-1:0] whit, fill;

    always_comb begin
        whit = '0;
        fill = '0;
        for (int i = 0; i < NW; i++) whit[i] = vld[i] && (addr[i] == waddr);
        // Scan downward so the last hit is the lowest free slot.
        for (int i = NW - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                fill    = '0;
                fill[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rdata = mem_rd;
        for (int i = 0; i < NW; i++) begin
            if (vld[i] && (addr[i] == raddr)) rdata = data[i];
        end
`ifdef ABSMEM_WR_BYPASS_EN
        if (wen_real && (waddr == raddr)) rdata = wdata;
`endif
        if (!ren_real) rdata = rrand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (wen_real) begin
            if (|whit) begin
                for (int i = 0; i < NW; i++) begin
                    if (whit[i]) data[i] <= wdata;
                end
            end else if (cnt < CW'(NW)) begin
                for (int i = 0; i < NW; i++) begin
                    if (fill[i]) begin
                        vld[i]  <= 1'b1;
                        addr[i] <= waddr;
                        data[i] <= wdata;
                    end
                end
                cnt <= cnt + CW'(1);
            end else begin
                ovf <= 1'b1;
            end
        end
    end
endmodule

module absmem_wlog #(
    parameter int AW  = 16,
    parameter int DW  = 8,
    parameter int TTS = 65536,
    parameter int NW  = 2
) (
    input  logic         clk,
    input  logic         rst,
    absmem_wlog_if.slave bus
);
    logic                       start_and_on;
    logic                       act;
    logic [DW-1:0]              mem [TTS];
    logic [1:0]                 ren_real, wen_real, ovf;
    logic [1:0][AW-1:0]         raddr, waddr;
    logic [1:0][DW-1:0]         wdata, rrand, rdata, mem_rd;
    logic [1:0][NW-1:0]         ent_vld;
    logic [1:0][NW-1:0][AW-1:0] ent_addr;
    logic [1:0][NW-1:0][DW-1:0] ent_data;
    logic                       vlg_cons, ila_cons;

    always_ff @(posedge clk) begin
        if (rst) start_and_on <= 1'b0;
        else if (bus.issue) start_and_on <= 1'b1;
    end

    // Never written or reset: the image keeps its free power-up contents.
    always_ff @(posedge clk) mem <= mem;

    assign act      = start_and_on & ~bus.compare;
    assign ren_real = {bus.ila_ren, bus.vlg_ren} & {2{act}};
    assign wen_real = {bus.ila_wen, bus.vlg_wen} & {2{act}};
    assign raddr    = {bus.ila_raddr, bus.vlg_raddr};
    assign waddr    = {bus.ila_waddr, bus.vlg_waddr};
    assign wdata    = {bus.ila_wdata, bus.vlg_wdata};
    assign rrand    = {bus.ila_r_rand_input, bus.vlg_r_rand_input};

    // Side 0 is the RTL view, side 1 the ILA view.
    for (genvar s = 0; s < 2; s++) begin : g_side
        assign mem_rd[s] = mem[raddr[s]];
        absmem_wlog_side #(.AW(AW), .DW(DW), .NW(NW)) u_side (
            .clk      (clk),
            .rst      (rst),
            .ren_real (ren_real[s]),
            .raddr    (raddr[s]),
            .mem_rd   (mem_rd[s]),
            .rrand    (rrand[s]),
            .rdata    (rdata[s]),
            .wen_real (wen_real[s]),
            .waddr    (waddr[s]),
            .wdata    (wdata[s]),
            .vld      (ent_vld[s]),
            .addr     (ent_addr[s]),
            .data     (ent_data[s]),
            .ovf      (ovf[s])
        );
    end

    // Every own entry must match the other side's view (its entry, else the image).
    function automatic logic side_cons(
        input logic [NW-1:0]          v,
        input logic [NW-1:0][AW-1:0]  a,
        input logic [NW-1:0][DW-1:0]  d,
        input logic [NW-1:0]          ov,
        input logic [NW-1:0][AW-1:0]  oa,
        input logic [NW-1:0][DW-1:0]  od
    );
        logic [DW-1:0] view;
        side_cons = 1'b1;
        for (int i = 0; i < NW; i++) begin
            if (v[i]) begin
                view = mem[a[i]];
                for (int j = 0; j < NW; j++) begin
                    if (ov[j] && (oa[j] == a[i])) view = od[j];
                end
                if (view != d[i]) side_cons = 1'b0;
            end
        end
    endfunction

    assign vlg_cons = side_cons(ent_vld[0], ent_addr[0], ent_data[0],
                                ent_vld[1], ent_addr[1], ent_data[1]);
    assign ila_cons = side_cons(ent_vld[1], ent_addr[1], ent_data[1],
                                ent_vld[0], ent_addr[0], ent_data[0]);

    assign bus.vlg_rdata = rdata[0];
    assign bus.ila_rdata = rdata[1];
    assign bus.vlg_ovf   = ovf[0];
    assign bus.ila_ovf   = ovf[1];
    assign bus.equal     = bus.compare & vlg_cons & ila_cons & ~ovf[0] & ~ovf[1];
endmodule

// File: tb/tb_absmem_wlog.sv
// Table-driven scoreboard bench for absmem_wlog (AW=16, DW=8, NW=2).
module tb_absmem_wlog;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    absmem_wlog_if #(.AW(16), .DW(8)) bus ();
    absmem_wlog #(.AW(16), .DW(8), .TTS(65536), .NW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit rs, nochk, issue, cmp;
        bit vw; logic [15:0] va; logic [7:0] vd;
        bit iw; logic [15:0] ia; logic [7:0] id;
        bit vr; logic [15:0] vra;
        bit ir; logic [15:0] ira;
        bit cv; logic [7:0] ev;
        bit ci; logic [7:0] ei;
        logic eq, vo, io;
    } vec_t;

    typedef struct {
        int   idx;
        vec_t v;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic [7:0] m01, m30, m31, m40, byp;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rs;
        bus.issue     = v.issue;
        bus.compare   = v.cmp;
        bus.vlg_wen   = v.vw;
        bus.vlg_waddr = v.va;
        bus.vlg_wdata = v.vd;
        bus.ila_wen   = v.iw;
        bus.ila_waddr = v.ia;
        bus.ila_wdata = v.id;
        bus.vlg_ren   = v.vr;
        bus.vlg_raddr = v.vra;
        bus.ila_ren   = v.ir;
        bus.ila_raddr = v.ira;
    endtask

    // The image is symbolic: learn it through reads of unlogged addresses.
    task automatic probe(input logic [15:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        bus.vlg_ren   = 1'b1;
        bus.vlg_raddr = a;
        @(negedge clk);
        d = bus.vlg_rdata;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("r%0d_equal", e.idx), int'(bus.equal), int'(e.v.eq));
            chk($sformatf("r%0d_vlg_ovf", e.idx), int'(bus.vlg_ovf), int'(e.v.vo));
            chk($sformatf("r%0d_ila_ovf", e.idx), int'(bus.ila_ovf), int'(e.v.io));
            if (e.v.cv) chk($sformatf("r%0d_vlg_rdata", e.idx), int'(bus.vlg_rdata), int'(e.v.ev));
            if (e.v.ci) chk($sformatf("r%0d_ila_rdata", e.idx), int'(bus.ila_rdata), int'(e.v.ei));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        exp_t e;
        idle = '{default: '0};
        drive(idle);
        rst = 1'b1;
        bus.vlg_r_rand_input = 8'hA5;
        bus.ila_r_rand_input = 8'h5C;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.issue = 1'b1;
        @(posedge clk); #1;
        bus.issue = 1'b0;
        probe(16'h0001, m01);
        probe(16'h0030, m30);
        probe(16'h0031, m31);
        probe(16'h0040, m40);
`ifdef ABSMEM_WR_BYPASS_EN
        byp = 8'h77;
`else
        byp = m40;
`endif

        // Reset state and reads before issue
        add('{rs:1, nochk:1, default:'0});
        add('{vr:1, vra:16'h10, ir:1, ira:16'h10, cv:1, ev:8'hA5, ci:1, ei:8'h5C, default:'0});
        add('{issue:1, vr:1, vra:16'h10, cv:1, ev:8'hA5, default:'0});
        // Matching writes on both sides; writes frozen under compare
        add('{vw:1, va:16'h10, vd:8'h5A, default:'0});
        add('{iw:1, ia:16'h10, id:8'h5A, vr:1, vra:16'h10, cv:1, ev:8'h5A, default:'0});
        add('{cmp:1, vw:1, va:16'h10, vd:8'hEE, ir:1, ira:16'h10, ci:1, ei:8'h5C, eq:1, default:'0});
        add('{cmp:1, eq:1, default:'0});
        add('{vr:1, vra:16'h10, cv:1, ev:8'h5A, default:'0});
        // Overflow on the third new address; coalescing still works when full
        add('{rs:1, nochk:1, default:'0});
        add('{issue:1, default:'0});
        add('{vw:1, va:16'h01, vd:8'hAA, default:'0});
        add('{vw:1, va:16'h02, vd:8'hBB, default:'0});
        add('{vw:1, va:16'h03, vd:8'hCC, default:'0});
        add('{cmp:1, vo:1, default:'0});
        add('{vr:1, vra:16'h01, cv:1, ev:8'hAA, vw:1, va:16'h02, vd:8'hDD, vo:1, default:'0});
        add('{vr:1, vra:16'h02, cv:1, ev:8'hDD, vo:1, default:'0});
        // Reset clears logs, count and sticky overflow
        add('{rs:1, nochk:1, default:'0});
        add('{issue:1, vr:1, vra:16'h01, cv:1, ev:8'hA5, default:'0});
        add('{vr:1, vra:16'h01, cv:1, ev:m01, vw:1, va:16'h05, vd:8'h11, iw:1, ia:16'h05, id:8'h11, default:'0});
        add('{vw:1, va:16'h06, vd:8'h22, iw:1, ia:16'h06, id:8'h22, default:'0});
        add('{cmp:1, eq:1, default:'0});
        // Same-address coalesce keeps count at 1
        add('{rs:1, nochk:1, default:'0});
        add('{issue:1, default:'0});
        add('{vw:1, va:16'h20, vd:8'h11, default:'0});
        add('{vw:1, va:16'h20, vd:8'h22, default:'0});
        add('{vr:1, vra:16'h20, cv:1, ev:8'h22, iw:1, ia:16'h20, id:8'h22, vw:1, va:16'h21, vd:8'h33, default:'0});
        add('{iw:1, ia:16'h21, id:8'h33, default:'0});
        add('{cmp:1, eq:1, default:'0});
        // Log entries checked against the shared image
        add('{rs:1, nochk:1, default:'0});
        add('{issue:1, default:'0});
        add('{vw:1, va:16'h30, vd:m30, default:'0});
        add('{cmp:1, eq:1, default:'0});
        add('{vw:1, va:16'h31, vd:~m31, default:'0});
        add('{cmp:1, default:'0});
        add('{iw:1, ia:16'h31, id:~m31, default:'0});
        add('{cmp:1, eq:1, default:'0});
        // Same-cycle read/write; no cross-side bypass; ILA-side overflow
        add('{rs:1, nochk:1, default:'0});
        add('{issue:1, default:'0});
        add('{vw:1, va:16'h40, vd:8'h77, vr:1, vra:16'h40, cv:1, ev:byp, ir:1, ira:16'h40, ci:1, ei:m40, default:'0});
        add('{vr:1, vra:16'h40, cv:1, ev:8'h77, ir:1, ira:16'h40, ci:1, ei:m40, default:'0});
        add('{iw:1, ia:16'h50, id:8'h01, default:'0});
        add('{iw:1, ia:16'h51, id:8'h02, default:'0});
        add('{iw:1, ia:16'h52, id:8'h03, default:'0});
        add('{cmp:1, io:1, default:'0});

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk); #1;
            drive(tbl[k]);
            if (!tbl[k].nochk) begin
                e.idx = k;
                e.v   = tbl[k];
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        drive(idle);
        for (int w = 0; w < 4 && sb.size() != 0; w++) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
